// File: rtl/reg_display_driver.sv
// reg_display_driver: captures a signed 8-bit register value, converts its
// magnitude to BCD with a shift-add-3 sequence, and drives two seven-segment
// digits plus sign and overflow indicators. One newer value can be queued
// while a conversion is running; only the most recent one is kept.
module reg_display_driver (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] value,
    input  logic       load,
    output logic [6:0] ten,
    output logic [6:0] one,
    output logic       neg,
    output logic       ovf,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        UPD  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_ZERO  = 7'b1111110;

    // Segment pattern {a..g} for a single decimal digit.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1111110;
            4'd1:    seg_code = 7'b0110000;
            4'd2:    seg_code = 7'b1101101;
            4'd3:    seg_code = 7'b1111001;
            4'd4:    seg_code = 7'b0110011;
            4'd5:    seg_code = 7'b1011011;
            4'd6:    seg_code = 7'b1011111;
            4'd7:    seg_code = 7'b1110000;
            4'd8:    seg_code = 7'b1111111;
            4'd9:    seg_code = 7'b1111011;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    // Unsigned magnitude of a two's-complement byte; -128 maps to 128.
    function automatic logic [7:0] abs8(input logic [7:0] v);
        abs8 = v[7] ? (~v + 8'd1) : v;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  mag_q, mag_d;
    logic [9:0]  bcd_q, bcd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        sign_q, sign_d;
    logic [7:0]  pend_q, pend_d;
    logic        pend_valid_q, pend_valid_d;
    logic [6:0]  ten_q, ten_d;
    logic [6:0]  one_q, one_d;
    logic        neg_q, neg_d;
    logic        ovf_q, ovf_d;

    logic [9:0]  bcd_adj;
    logic [7:0]  start_src;
    logic        ovf_now;

    // Next-state, datapath and display update logic.
    always_comb begin
        state_d      = state_q;
        mag_d        = mag_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        sign_d       = sign_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        ten_d        = ten_q;
        one_d        = one_q;
        neg_d        = neg_q;
        ovf_d        = ovf_q;

        // Add-3 correction on the nibbles before each shift; the 2-bit
        // hundreds field can never reach 5 for magnitudes up to 128.
        bcd_adj = bcd_q;
        if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
        if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;

        // A fresh load always beats a queued value when starting.
        start_src = load ? value : pend_q;
        ovf_now   = (bcd_q[9:8] != 2'd0);

        case (state_q)
            IDLE: begin
                if (load) begin
                    mag_d   = abs8(value);
                    sign_d  = value[7];
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d = {bcd_adj[8:0], mag_q[7]};
                mag_d = {mag_q[6:0], 1'b0};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = UPD;
                if (load) begin
                    pend_d       = value;
                    pend_valid_d = 1'b1;
                end
            end
            UPD: begin
                neg_d = sign_q;
                ovf_d = ovf_now;
                if (ovf_now) begin
                    ten_d = SEG_DASH;
                    one_d = SEG_DASH;
                end else begin
                    one_d = seg_code(bcd_q[3:0]);
                    ten_d = (bcd_q[7:4] == 4'd0) ? SEG_BLANK : seg_code(bcd_q[7:4]);
                end
                if (load || pend_valid_q) begin
                    mag_d        = abs8(start_src);
                    sign_d       = start_src[7];
                    bcd_d        = '0;
                    cnt_d        = '0;
                    pend_valid_d = 1'b0;
                    state_d      = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            mag_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            sign_q       <= 1'b0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            ten_q        <= SEG_BLANK;
            one_q        <= SEG_ZERO;
            neg_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mag_q        <= mag_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            sign_q       <= sign_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            ten_q        <= ten_d;
            one_q        <= one_d;
            neg_q        <= neg_d;
            ovf_q        <= ovf_d;
        end
    end

    assign ten  = ten_q;
    assign one  = one_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_reg_display_driver.sv
// Testbench for reg_display_driver: a transaction-level model predicts when
// each conversion lands on the display and what it shows; a monitor checks
// the held display and busy flag every cycle against those predictions.
module tb_reg_display_driver;

    logic       clock = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] value;
    logic [6:0] ten;
    logic [6:0] one;
    logic       neg;
    logic       ovf;
    logic       busy;

    reg_display_driver dut (
        .clock (clock),
        .reset (reset),
        .value (value),
        .load  (load),
        .ten   (ten),
        .one   (one),
        .neg   (neg),
        .ovf   (ovf),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    localparam logic [6:0] SEG [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    typedef struct {
        int unsigned cyc;
        logic [6:0]  ten;
        logic [6:0]  one;
        logic        neg;
        logic        ovf;
    } disp_t;

    disp_t       disp_q[$];
    logic        busy_q[$];
    int unsigned cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    // Expected display for a signed byte, from decimal arithmetic.
    function automatic disp_t expect_disp(input int unsigned c, input logic [7:0] v);
        disp_t d;
        int    sv;
        int    mag;
        sv    = int'($signed(v));
        mag   = (sv < 0) ? -sv : sv;
        d.cyc = c;
        d.neg = (sv < 0);
        d.ovf = (mag >= 100);
        if (d.ovf) begin
            d.ten = 7'b0000001;
            d.one = 7'b0000001;
        end else begin
            d.ten = (mag / 10 == 0) ? 7'b0000000 : SEG[mag / 10];
            d.one = SEG[mag % 10];
        end
        return d;
    endfunction

    // Transaction model: each conversion takes 9 edges from its start;
    // on completion a simultaneous load or the queued value starts next.
    bit          m_active = 1'b0;
    bit          m_pend_v = 1'b0;
    logic [7:0]  m_cur    = '0;
    logic [7:0]  m_pend   = '0;
    int unsigned m_done   = 0;

    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
        if (reset) begin
            disp_t r;
            r.cyc = cyc; r.ten = 7'b0000000; r.one = SEG[0]; r.neg = 1'b0; r.ovf = 1'b0;
            disp_q.push_back(r);
            m_active = 1'b0;
            m_pend_v = 1'b0;
        end else if (m_active && cyc == m_done) begin
            disp_q.push_back(expect_disp(cyc, m_cur));
            if (load) begin
                m_cur = value; m_done = cyc + 9; m_pend_v = 1'b0;
            end else if (m_pend_v) begin
                m_cur = m_pend; m_done = cyc + 9; m_pend_v = 1'b0;
            end else begin
                m_active = 1'b0;
            end
        end else if (m_active) begin
            if (load) begin
                m_pend = value; m_pend_v = 1'b1;
            end
        end else if (load) begin
            m_active = 1'b1; m_cur = value; m_done = cyc + 9;
        end
        busy_q.push_back(m_active);
    end

    // Monitor: adopt predicted updates when due, check held outputs and busy.
    disp_t held;
    bit    held_v = 1'b0;

    initial forever begin
        @(posedge clock);
        #1;
        while (disp_q.size() > 0 && disp_q[0].cyc <= cyc) begin
            held   = disp_q.pop_front();
            held_v = 1'b1;
        end
        if (held_v) begin
            checks++;
            if ({ten, one, neg, ovf} !== {held.ten, held.one, held.neg, held.ovf}) begin
                errors++;
                $display("FAIL display cyc=%0d got ten=%b one=%b neg=%b ovf=%b want ten=%b one=%b neg=%b ovf=%b",
                         cyc, ten, one, neg, ovf, held.ten, held.one, held.neg, held.ovf);
            end
        end
        if (busy_q.size() > 0) begin
            logic eb;
            eb = busy_q.pop_front();
            checks++;
            if (busy !== eb) begin
                errors++;
                $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, eb);
            end
        end
    end

    task automatic step(input logic ld, input logic [7:0] v, input logic rst);
        @(negedge clock);
        load  = ld;
        value = v;
        reset = rst;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'd0, 1'b0);
    endtask

    task automatic ld(input logic [7:0] v);
        step(1'b1, v, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        value = 8'd0;
        repeat (3) step(1'b0, 8'd0, 1'b1);
        idle(2);

        ld(8'd37);  idle(12);
        ld(8'hF9);  idle(12);
        ld(8'd100); idle(12);
        ld(8'h80);  idle(12);
        ld(8'd99);  idle(12);
        ld(8'd0);   idle(12);

        ld(8'd5); idle(2); ld(8'd12); idle(1); ld(8'd64); idle(16);

        ld(8'd42); idle(3); step(1'b0, 8'd0, 1'b1); idle(1); ld(8'd8); idle(12);

        ld(8'd3); idle(8); ld(8'd21); idle(12);

        ld(8'd10); idle(8); step(1'b1, 8'd7, 1'b1); idle(12);

        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 2)       step(1'b0, 8'd0, 1'b1);
            else if (r < 20) step(1'b1, 8'($urandom), 1'b0);
            else             step(1'b0, 8'd0, 1'b0);
        end
        idle(25);

        checks++;
        if (disp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending updates want 0", disp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_display_driver.md
# reg_display_driver

Sequential display stage that takes the 8-bit register-file write-back value from the CPU datapath and drives a two-digit seven-segment display plus a sign LED. The block sits directly downstream of the CPU top level and consumes its register output bus. It captures a value on a load strobe and converts the signed two's-complement value to sign plus decimal magnitude. The conversion is a multi-cycle shift-add-3 (double-dabble) sequence. The block holds the displayed result stable until the next conversion completes.

## Interface
Parameters:
- none; widths are fixed: 8-bit data, 7-bit segment fields.

Ports:
- clock  in  1  system clock (post-divider clock in the top level); all state changes on its rising edge.
- reset  in  1  synchronous, active-high; one clock, one synchronous active-high reset.
- value  in  8  signed two's-complement register value to display.
- load  in  1  one-cycle capture strobe for `value`.
- ten  out  7  tens-digit segments {a,b,c,d,e,f,g}, bit6=a, active-high.
- one  out  7  ones-digit segments, same encoding.
- neg  out  1  1 = displayed value is negative.
- ovf  out  1  1 = magnitude ≥ 100; digits show dashes.
- busy  out  1  1 = conversion in progress.

## Operation
Digit codes:
- 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
- 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- blank=0000000, dash=0000001.

State machine, states IDLE, CONV and UPD:
- **IDLE, load=1:**
  - mag ← |value| (8-bit unsigned; -128 gives 128).
  - sign ← value[7]; bcd ← 0 (10 bits: hundreds[1:0], tens[3:0], ones[3:0]).
  - cnt ← 0; go to CONV.
- **CONV:** each edge, add 3 to every BCD nibble ≥5, then shift {bcd,mag} left by 1 and increment cnt. After the 8th shift, go to UPD.
- **UPD (one edge):**
  - Register neg ← sign.
  - Register ovf ← (hundreds ≠ 0).
  - If ovf, ten = one = dash.
  - Otherwise one = code(ones), and ten = blank when tens = 0 (leading-zero blanking), else code(tens).
- **Leaving UPD:**
  - If load=1 on that edge, start a new conversion from `value` and clear pending.
  - Else if pending is valid, start from the pending value and clear pending.
  - Else go to IDLE.
- **Pending buffer (1 entry):**
  - load=1 while in CONV, or in UPD when superseded: pending ← value, pend_valid ← 1.
  - A newer load overwrites an older pending value. Only the newest value is kept; intermediate values are dropped.
- **Outputs between updates:** ten, one, neg and ovf change only on UPD edges and are otherwise held.

## Timing
- Load sampled at edge E0. Shifts occur at E1..E8. Outputs update at E9.
- Latency: 9 clocks from load edge to new display.
- busy: 1 after E0 through E9. busy=0 after E9 only if the FSM returns to IDLE. On chained conversions busy stays 1 continuously.
- A chained conversion started at UPD edge Ek updates outputs at Ek+9.
- Reset values: ten=blank, one=code(0), neg=0, ovf=0, busy=0, pend_valid=0, state=IDLE.
- Reset mid-conversion aborts the conversion and clears pending. Outputs return to reset values on that edge.
- Reset has priority over load on the same edge.
- Value 0: ten blank, one code(0), neg=0. There is no negative zero.

## Test plan
- Load 8'd37 at E0, idle afterwards:
  - At E9: ten=1111001, one=1110000, neg=0, ovf=0.
  - busy high for 9 cycles.
- Load 8'hF9 (−7):
  - At E9: ten=0000000, one=1110000, neg=1.
- Overflow cases, each after 9 cycles:
  - Load 8'd100: ovf=1, neg=0, ten=one=0000001.
  - Load 8'h80 (−128): ovf=1, neg=1, dashes.
  - Then load 8'd99: ten=one=1111011, ovf=0.
- Back-to-back loads: 8'd5 at E0, 8'd12 at E3, 8'd64 at E5.
  - At E9: display 5 (ten blank, one 1011011).
  - At E18: display 64 (ten 1011111, one 0110011).
  - 12 is never shown; busy is continuous E1..E18.
- Load 8'd42 at E0, reset at E4:
  - After E4: reset values, busy=0.
  - Load 8'd8 at E6 gives one=1111111 and ten blank at E15.
- Load coinciding with the UPD edge (load 8'd21 at E9 after load 8'd3 at E0):
  - Display 3 at E9, then 21 at E18.
